// File: rtl/keypad_pkg.sv
// Shared types and key decoding for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  // Indexed [row][column]; column 0 is the one driven by cols[0].
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] keycode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return KEYMAP[row_idx][col_idx];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle level
// of pulled-up, active-low lines).
module sync_2ff #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_p0 <= '1;
      q       <= '1;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, press/release debounce, one code per
// press, and a two-digit shift register feeding the seven-segment display.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 48000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]    rs;
  logic [PW-1:0] period_cnt;
  logic          sample;
  state_t        state;
  logic [CW-1:0] deb_cnt;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [1:0]    hit_row;
  logic [1:0]    hit_col;
  logic          row_low;
  logic [3:0]    cols_rot;
  logic [3:0]    code;

  sync_2ff #(.DATA_W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rs)
  );

  assign sample   = (period_cnt == PW'(SCAN_DIV - 1));
  assign row_low  = ~rs[row_idx];
  assign cols_rot = {cols[2:0], cols[3]};
  assign code     = keycode(row_idx, col_idx);

  always_ff @(posedge clk) begin
    if (!reset)      period_cnt <= '0;
    else if (sample) period_cnt <= '0;
    else             period_cnt <= period_cnt + PW'(1);
  end

  // Lowest-index low row wins when several keys share the active column.
  always_comb begin
    hit_row = 2'd0;
    if      (!rs[0]) hit_row = 2'd0;
    else if (!rs[1]) hit_row = 2'd1;
    else if (!rs[2]) hit_row = 2'd2;
    else if (!rs[3]) hit_row = 2'd3;
  end

  always_comb begin
    hit_col = 2'd0;
    case (cols)
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      4'b0111: hit_col = 2'd3;
      default: hit_col = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      cols      <= 4'b1110;
      deb_cnt   <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (sample) begin
        case (state)
          SCAN: begin
            if (rs == 4'b1111) begin
              cols <= cols_rot;
            end else begin
              row_idx <= hit_row;
              col_idx <= hit_col;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!row_low) begin
              state <= SCAN;
              cols  <= cols_rot;
            end else if (deb_cnt == CW'(DEBOUNCE_CNT - 1)) begin
              deb_cnt   <= deb_cnt + CW'(1);
              key_valid <= 1'b1;
              key_code  <= code;
              digit_old <= digit_new;
              digit_new <= code;
              state     <= HELD;
            end else begin
              deb_cnt <= deb_cnt + CW'(1);
            end
          end
          // Only the captured row matters until it is released.
          HELD: begin
            if (!row_low) begin
              deb_cnt <= '0;
              state   <= RELEASE;
            end
          end
          RELEASE: begin
            if (row_low) begin
              state <= HELD;
            end else if (deb_cnt == CW'(DEBOUNCE_CNT - 1)) begin
              state <= SCAN;
              cols  <= cols_rot;
            end else begin
              deb_cnt <= deb_cnt + CW'(1);
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner at SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  int checks = 0;
  int errors = 0;
  int e      = 0;
  int pulses = 0;
  int dbl    = 0;
  logic prev_kv = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts key_valid pulses and back-to-back highs.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (key_valid === 1'b1) pulses++;
      if (key_valid === 1'b1 && prev_kv === 1'b1) dbl++;
    end
    prev_kv = key_valid;
  end

  typedef struct {
    logic [3:0] rows;
    int         at_edge;
    logic [3:0] cols;
    logic       kv;
    logic [3:0] code;
    logic [3:0] dnew;
    logic [3:0] dold;
    int         pulses;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] r, input int at, input logic [3:0] c,
                              input logic kv, input logic [3:0] cd, input logic [3:0] dn,
                              input logic [3:0] dd, input int p);
    vec_t v;
    v.rows = r; v.at_edge = at; v.cols = c; v.kv = kv;
    v.code = cd; v.dnew = dn; v.dold = dd; v.pulses = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Advance n clock edges; returns 1 ns after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rows  = 4'b0000;
    step(3);
    chk("rst_cols", 32'(cols), 32'(4'b1110));
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_new", 32'(digit_new), 32'd0);
    chk("rst_old", 32'(digit_old), 32'd0);
    e     = 0;
    reset = 1'b1;
    rows  = 4'b1111;

    // Idle scan, one column step per 4 cycles
    vq.push_back(mk(4'b1111,   3, 4'b1110, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1111,   4, 4'b1101, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1111,   8, 4'b1011, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1111,  12, 4'b0111, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1111,  16, 4'b1110, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1111,  20, 4'b1101, 0, 4'h0, 4'h0, 4'h0, 0));
    // Press '5' while column 1 is driven; detect at 24, accept at 36
    vq.push_back(mk(4'b1101,  24, 4'b1101, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1101,  35, 4'b1101, 0, 4'h0, 4'h0, 4'h0, 0));
    vq.push_back(mk(4'b1101,  36, 4'b1101, 1, 4'h5, 4'h5, 4'h0, 0));
    vq.push_back(mk(4'b1101,  37, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1101,  60, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    // One-sample release bounce, then second row low while held
    vq.push_back(mk(4'b1111,  64, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1101,  80, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1001, 100, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1101, 120, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    // Full release: back to SCAN at 136
    vq.push_back(mk(4'b1111, 135, 4'b1101, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1111, 136, 4'b1011, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1111, 140, 4'b0111, 0, 4'h5, 4'h5, 4'h0, 1));
    // Press 'A' (row 0, column 3)
    vq.push_back(mk(4'b1110, 155, 4'b0111, 0, 4'h5, 4'h5, 4'h0, 1));
    vq.push_back(mk(4'b1110, 156, 4'b0111, 1, 4'hA, 4'hA, 4'h5, 1));
    vq.push_back(mk(4'b1110, 160, 4'b0111, 0, 4'hA, 4'hA, 4'h5, 2));
    vq.push_back(mk(4'b1111, 175, 4'b0111, 0, 4'hA, 4'hA, 4'h5, 2));
    vq.push_back(mk(4'b1111, 176, 4'b1110, 0, 4'hA, 4'hA, 4'h5, 2));
    vq.push_back(mk(4'b1111, 184, 4'b1011, 0, 4'hA, 4'hA, 4'h5, 2));
    // Press bounce on column 2: one low sample then high
    vq.push_back(mk(4'b1101, 188, 4'b1011, 0, 4'hA, 4'hA, 4'h5, 2));
    vq.push_back(mk(4'b1111, 191, 4'b1011, 0, 4'hA, 4'hA, 4'h5, 2));
    vq.push_back(mk(4'b1111, 192, 4'b0111, 0, 4'hA, 4'hA, 4'h5, 2));
    vq.push_back(mk(4'b1111, 200, 4'b1101, 0, 4'hA, 4'hA, 4'h5, 2));

    foreach (vq[i]) begin
      rows = vq[i].rows;
      step(vq[i].at_edge - e);
      chk($sformatf("v%0d_cols", i), 32'(cols), 32'(vq[i].cols));
      chk($sformatf("v%0d_kv", i), 32'(key_valid), 32'(vq[i].kv));
      chk($sformatf("v%0d_code", i), 32'(key_code), 32'(vq[i].code));
      chk($sformatf("v%0d_new", i), 32'(digit_new), 32'(vq[i].dnew));
      chk($sformatf("v%0d_old", i), 32'(digit_old), 32'(vq[i].dold));
      chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vq[i].pulses));
    end

    // Reset after 2 of 3 good debounce samples of '5'
    rows = 4'b1101;
    step(204 - e);
    chk("mid_detect_cols", 32'(cols), 32'(4'b1101));
    step(212 - e);
    chk("mid_pre_kv", 32'(key_valid), 32'd0);
    reset = 1'b0;
    rows  = 4'b1111;
    step(1);
    reset = 1'b1;
    chk("mid_rst_cols", 32'(cols), 32'(4'b1110));
    chk("mid_rst_kv", 32'(key_valid), 32'd0);
    chk("mid_rst_new", 32'(digit_new), 32'd0);
    chk("mid_rst_old", 32'(digit_old), 32'd0);
    step(20);
    chk("mid_after_pulses", 32'(pulses), 32'd2);
    chk("mid_after_cols", 32'(cols), 32'(4'b1101));
    chk("mid_after_new", 32'(digit_new), 32'd0);
    chk("mid_after_old", 32'(digit_old), 32'd0);
    chk("no_double_pulse", 32'(dbl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
